// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH+1 busy cycles; Start/MTHI/MTLO are only honoured when idle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             MTHI,
  input  logic             MTLO,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             Flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               qbit;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;

  assign signed_op = ~Op[0];
  assign a_neg     = signed_op & OperandA[WIDTH-1];
  assign b_neg     = signed_op & OperandB[WIDTH-1];

  // Multiply: acc holds {partial product, consumed multiplier bits}, shifted right each step.
  assign mul_add  = b_q[0] ? a_q : {WIDTH{1'b0}};
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc holds {remainder, quotient}; dividend bits stream in from the top of a_q.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign qbit      = ~div_diff[WIDTH];
  assign div_next  = {(qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], qbit};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    a_raw_d   = a_raw_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Flush) begin
          if (Start) begin
            is_div_d  = Op[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            divz_d    = (OperandB == {WIDTH{1'b0}});
            a_raw_d   = OperandA;
            a_d       = a_neg ? -OperandA : OperandA;
            b_d       = b_neg ? -OperandB : OperandB;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = S_RUN;
          end else begin
            if (MTHI) hi_d = WriteData;
            if (MTLO) lo_d = WriteData;
          end
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_next;
            a_d   = a_q << 1;
          end else begin
            acc_d = mul_next;
            b_d   = b_q >> 1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!Flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (divz_q) begin
            hi_d = a_raw_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      a_raw_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      a_raw_q   <= a_raw_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: arithmetic results, latency, HI/LO moves, reset and flush.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA, OperandB, WriteData;
  logic        MTHI, MTLO, Flush;
  logic [31:0] HI, LO;
  logic        Busy, Done;

  int n_checks = 0;
  int n_pass   = 0;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .MTHI(MTHI), .MTLO(MTLO), .WriteData(WriteData), .Flush(Flush),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cycles;
    tick();
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    tick();
    Start = 1'b0; OperandA = $urandom; OperandB = $urandom;
    cycles = 0;
    while (Busy && cycles < 60) begin
      cycles++;
      tick();
    end
    check({tag, ".busy_cycles"}, 64'(cycles), 64'd33);
    check({tag, ".done"}, 64'(Done), 64'd1);
    check({tag, ".hi"}, 64'(HI), 64'(exp_hi));
    check({tag, ".lo"}, 64'(LO), 64'(exp_lo));
    tick();
    check({tag, ".done_clear"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int cycles;
    logic saw_done;
    Rst = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
    MTHI = 1'b0; MTLO = 1'b0; WriteData = '0; Flush = 1'b0;
    #12;
    check("reset.hi", 64'(HI), 64'd0);
    check("reset.lo", 64'(LO), 64'd0);
    check("reset.busy", 64'(Busy), 64'd0);
    check("reset.done", 64'(Done), 64'd0);
    Rst = 1'b0;

    run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg7x3", 2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7_2",   2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
    run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_100_m7", 2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
    run_op("div_m100_7", 2'b10, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    run_op("divu_by0",   2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_by0",    2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // HI/LO moves from idle
    tick();
    MTHI = 1'b1; WriteData = 32'hDEAD_BEEF;
    tick();
    MTHI = 1'b0;
    check("mthi.hi", 64'(HI), 64'hDEAD_BEEF);
    check("mthi.lo_kept", 64'(LO), 64'hFFFF_FFFF);
    MTLO = 1'b1; WriteData = 32'h1234_5678;
    tick();
    MTLO = 1'b0;
    check("mtlo.lo", 64'(LO), 64'h1234_5678);

    // Start wins over MTLO; MTHI and Start while busy are dropped
    Start = 1'b1; Op = 2'b01; OperandA = 32'd3; OperandB = 32'd5; MTLO = 1'b1; WriteData = 32'h0000_AAAA;
    tick();
    Start = 1'b0; MTLO = 1'b0;
    check("start_mtlo.lo_kept", 64'(LO), 64'h1234_5678);
    repeat (5) tick();
    MTHI = 1'b1; WriteData = 32'h0000_BBBB; Start = 1'b1; Op = 2'b00; OperandA = 32'd9; OperandB = 32'd9;
    tick();
    MTHI = 1'b0; Start = 1'b0;
    check("busy_mthi.hi_kept", 64'(HI), 64'hDEAD_BEEF);
    cycles = 0;
    while (Busy && cycles < 60) begin
      cycles++;
      tick();
    end
    check("busy_ign.done", 64'(Done), 64'd1);
    check("busy_ign.hi", 64'(HI), 64'd0);
    check("busy_ign.lo", 64'(LO), 64'd15);
    tick();
    check("busy_ign.no_restart", 64'(Busy), 64'd0);

    // Asynchronous reset in the middle of iteration 10
    Start = 1'b1; Op = 2'b01; OperandA = 32'h0000_0777; OperandB = 32'h0000_0333;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    #2 Rst = 1'b1;
    #1;
    check("async_rst.hi", 64'(HI), 64'd0);
    check("async_rst.lo", 64'(LO), 64'd0);
    check("async_rst.busy", 64'(Busy), 64'd0);
    #1 Rst = 1'b0;

    // Flush at iteration 10 keeps the pre-operation HI/LO
    tick();
    MTHI = 1'b1; MTLO = 1'b1; WriteData = 32'h0000_0011;
    tick();
    MTLO = 1'b1; MTHI = 1'b0; WriteData = 32'h0000_0022;
    tick();
    MTLO = 1'b0;
    check("flush.pre_hi", 64'(HI), 64'h11);
    check("flush.pre_lo", 64'(LO), 64'h22);
    Start = 1'b1; Op = 2'b00; OperandA = 32'h0000_0100; OperandB = 32'h0000_0200;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush.busy", 64'(Busy), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      saw_done |= Done;
      tick();
    end
    check("flush.no_done", 64'(saw_done), 64'd0);
    check("flush.hi", 64'(HI), 64'h11);
    check("flush.lo", 64'(LO), 64'h22);

    // Flush in idle suppresses MTHI and Start
    Flush = 1'b1; MTHI = 1'b1; WriteData = 32'h0000_0099;
    tick();
    MTHI = 1'b0; Start = 1'b1; Op = 2'b11; OperandA = 32'd8; OperandB = 32'd2;
    tick();
    Flush = 1'b0; Start = 1'b0;
    check("idle_flush.hi", 64'(HI), 64'h11);
    check("idle_flush.busy", 64'(Busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage iterative multiply/divide unit and owner of the HI/LO registers.
- Consumes operands and HI/LO control captured in the decode/execute pipeline register: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Presents HI/LO to the execute-stage MFHI/MFLO mux.
- Drives Busy back to the hazard unit, which stalls decode and holds the decode/execute register while an operation runs.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- Clk  input  1  clock, all state updates on posedge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  begin operation selected by Op; sampled only in IDLE.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA  input  WIDTH  rs value (multiplicand / dividend).
- OperandB  input  WIDTH  rt value (multiplier / divisor).
- MTHI  input  1  write WriteData to HI.
- MTLO  input  1  write WriteData to LO.
- WriteData  input  WIDTH  rs value for MTHI/MTLO.
- Flush  input  1  synchronous abort of an in-flight operation.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- Busy  output  1  high whenever state != IDLE (combinational from state).
- Done  output  1  one-cycle pulse, coincident with new HI/LO values.

Behaviour:
- Reset: async on Rst rising, independent of Clk.
  - HI=0, LO=0, state=IDLE, counter=0, Done=0, Busy=0.
  - Reset mid-operation discards all working state immediately.
- States: IDLE, RUN, FIX.
- IDLE:
  - Start=1 at edge k: latch Op, |A|, |B| (magnitudes for MULT/DIV; raw values for MULTU/DIVU), and the result-sign flags. Clear the 2*WIDTH accumulator and set counter=0. Go to RUN.
  - If Start=0, MTHI=1 loads HI<=WriteData and MTLO=1 loads LO<=WriteData. Both may be asserted together.
  - Start has priority: when Start=1, MTHI/MTLO in the same cycle are ignored.
- RUN: one iteration per edge, WIDTH iterations (edges k+1..k+32). After iteration WIDTH go to FIX.
  - Multiply: radix-2 shift-add, LSB-first over the multiplier.
  - Divide: restoring division, one quotient bit per iteration, MSB-first.
- FIX (edge k+33): apply sign correction, write HI/LO, pulse Done, go to IDLE.
  - MULT: 64-bit product negated if sign(A)!=sign(B); HI=upper, LO=lower.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Divide results: LO=quotient, HI=remainder, truncated to WIDTH.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero (B==0, DIV or DIVU): HI=OperandA as captured, LO=0xFFFFFFFF. Latency is unchanged.
- Latency:
  - Busy is high for exactly WIDTH+1 cycles after the accepting edge.
  - Done=1 and new HI/LO are visible from edge k+33 for one cycle.
  - Start is accepted again at edge k+34.
- While Busy, Start, MTHI and MTLO are ignored; the hazard unit must not issue them.
- Flush:
  - In RUN/FIX: state<=IDLE at the next edge, HI/LO keep their pre-operation values, no Done pulse.
  - In IDLE, Flush suppresses Start/MTHI/MTLO for that cycle.
- HI/LO change only via FIX, MTHI/MTLO in IDLE, or Rst.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles, Done at edge k+33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFF9 (-7), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 -> same 33-cycle latency, HI=0x1234, LO=0xFFFFFFFF.
- IDLE: MTHI WriteData=0xDEADBEEF -> HI=0xDEADBEEF next edge. Start+MTLO same cycle -> MTLO ignored. MTHI and a second Start during Busy -> ignored, result unchanged.
- Rst asserted mid-edge at iteration 10 -> HI=LO=0 and Busy=0 without waiting for Clk. Flush at iteration 10 (HI=0x11, LO=0x22 beforehand) -> IDLE next edge, HI=0x11, LO=0x22, no Done.
